// File: rtl/snn_pkg.sv
// Shared types and helpers for the time-multiplexed LIF layer.
package snn_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_t;

    localparam logic [15:0] CNT_BASE_ADDR = 16'h8000;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] x,
                                                        input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational leaky integrate-and-fire update for one neuron.
module lif_update_unit
    import snn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = 19,
    parameter int REF_W = 8
) (
    input  logic signed [WIDTH-1:0] i_v,
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic signed [WIDTH-1:0] i_leak,
    input  logic signed [WIDTH-1:0] i_threshold,
    input  logic signed [WIDTH-1:0] i_reset_potential,
    input  logic signed [WIDTH-1:0] i_refractory_cycles,
    input  logic        [REF_W-1:0] i_ref,
    output logic signed [WIDTH-1:0] o_v_next,
    output logic        [REF_W-1:0] o_ref_next,
    output logic                    o_spike
);

    logic signed [63:0]      w_sum;
    logic signed [63:0]      w_rc;
    logic signed [63:0]      w_ref_max;
    logic signed [WIDTH-1:0] w_v_sat;
    logic        [REF_W-1:0] w_ref_clamp;

    always_comb begin
        w_sum     = 64'(i_v) - 64'(i_leak) + 64'(i_acc);
        w_v_sat   = WIDTH'(sat_to_width(w_sum, WIDTH));
        w_rc      = 64'(i_refractory_cycles);
        w_ref_max = (64'sd1 <<< REF_W) - 64'sd1;
        if (w_rc < 64'sd0)          w_ref_clamp = '0;
        else if (w_rc > w_ref_max)  w_ref_clamp = '1;
        else                        w_ref_clamp = REF_W'(w_rc);

        o_v_next   = w_v_sat;
        o_ref_next = '0;
        o_spike    = 1'b0;
        // A refractory neuron neither integrates nor leaks.
        if (i_ref != '0) begin
            o_v_next   = i_v;
            o_ref_next = i_ref - REF_W'(1);
        end else if (w_v_sat >= i_threshold) begin
            o_spike    = 1'b1;
            o_v_next   = i_reset_potential;
            o_ref_next = w_ref_clamp;
        end
    end

endmodule

// File: rtl/tm_lif_layer.sv
// Time-multiplexed fully connected LIF layer sharing one accumulate/update datapath.
// Optional per-neuron spike counters at 16'h8000+j when TM_LIF_SPIKE_COUNT_EN is defined.
module tm_lif_layer
    import snn_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 3,
    parameter int REF_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wr_en,
    input  logic [15:0]        cfg_addr,
    input  logic [WIDTH-1:0]   cfg_wr_data,
    output logic [WIDTH-1:0]   cfg_rd_data,
    input  logic [WIDTH-1:0]   threshold,
    input  logic [WIDTH-1:0]   leak,
    input  logic [WIDTH-1:0]   reset_potential,
    input  logic [WIDTH-1:0]   refractory_cycles,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_IN-1:0]  in_spikes,
    output logic               out_valid,
    output logic [NUM_OUT-1:0] out_spikes,
    output logic               busy
);

    localparam int NW    = NUM_IN * NUM_OUT;
    localparam int ACC_W = WIDTH + $clog2(NUM_IN) + 1;
    localparam int I_W   = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1;
    localparam int J_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int AW    = (NW      > 1) ? $clog2(NW)      : 1;
    localparam logic [15:0] NW_A = 16'(NW);

    state_t                  r_state, w_next;
    logic [NUM_IN-1:0]       r_in;
    logic [I_W-1:0]          r_i;
    logic [J_W-1:0]          r_j;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [WIDTH-1:0] r_w   [NW];
    logic signed [WIDTH-1:0] r_v   [NUM_OUT];
    logic [REF_W-1:0]        r_ref [NUM_OUT];
    logic [NUM_OUT-1:0]      r_spk, r_out_spikes;
    logic                    r_out_valid;
    logic [WIDTH-1:0]        r_rd_data, w_rd_data;
    logic signed [WIDTH-1:0] w_wsel, w_v_next;
    logic [REF_W-1:0]        w_ref_next;
    logic                    w_spike, w_i_last, w_j_last;

    assign w_wsel   = r_w[AW'(r_i * NUM_OUT + r_j)];
    assign w_i_last = (r_i == I_W'(NUM_IN - 1));
    assign w_j_last = (r_j == J_W'(NUM_OUT - 1));

    lif_update_unit #(.WIDTH(WIDTH), .ACC_W(ACC_W), .REF_W(REF_W)) u_upd (
        .i_v                 (r_v[r_j]),
        .i_acc               (r_acc),
        .i_leak              (leak),
        .i_threshold         (threshold),
        .i_reset_potential   (reset_potential),
        .i_refractory_cycles (refractory_cycles),
        .i_ref               (r_ref[r_j]),
        .o_v_next            (w_v_next),
        .o_ref_next          (w_ref_next),
        .o_spike             (w_spike)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = ACCUM;
            ACCUM:   if (w_i_last) w_next = UPDATE;
            UPDATE:  w_next = w_j_last ? DONE : ACCUM;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in         <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_acc        <= '0;
            r_spk        <= '0;
            r_out_spikes <= '0;
            r_out_valid  <= 1'b0;
            for (int k = 0; k < NUM_OUT; k++) begin
                r_v[k]   <= '0;
                r_ref[k] <= '0;
            end
        end else begin
            r_out_valid <= (r_state == DONE);
            case (r_state)
                IDLE: if (in_valid) begin
                    r_in  <= in_spikes;
                    r_i   <= '0;
                    r_j   <= '0;
                    r_acc <= '0;
                    r_spk <= '0;
                end
                ACCUM: begin
                    if (r_in[r_i]) r_acc <= r_acc + ACC_W'(w_wsel);
                    if (!w_i_last) r_i <= r_i + I_W'(1);
                end
                UPDATE: begin
                    r_v[r_j]   <= w_v_next;
                    r_ref[r_j] <= w_ref_next;
                    r_spk[r_j] <= w_spike;
                    r_i        <= '0;
                    r_j        <= r_j + J_W'(1);
                    r_acc      <= '0;
                end
                DONE:    r_out_spikes <= r_spk;
                default: ;
            endcase
        end
    end

    // Datapath reads see the pre-write value; the write still lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NW; k++) r_w[k] <= '0;
            r_rd_data <= '0;
        end else begin
            if (cfg_wr_en && cfg_addr < NW_A) r_w[AW'(cfg_addr)] <= cfg_wr_data;
            r_rd_data <= w_rd_data;
        end
    end

`ifdef TM_LIF_SPIKE_COUNT_EN
    localparam logic [15:0] NOUT_A = 16'(NUM_OUT);
    logic [15:0] r_cnt [NUM_OUT];
    logic        w_upd;
    assign w_upd = (r_state == UPDATE);

    // A config write to the counter address clears it even if a spike lands that cycle.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_OUT; k++) begin
            if (rst)
                r_cnt[k] <= '0;
            else if (cfg_wr_en && cfg_addr == CNT_BASE_ADDR + 16'(k))
                r_cnt[k] <= '0;
            else if (w_upd && w_spike && r_j == J_W'(k) && r_cnt[k] != 16'hFFFF)
                r_cnt[k] <= r_cnt[k] + 16'd1;
        end
    end
`endif

    always_comb begin
        w_rd_data = '0;
        if (cfg_addr < NW_A) w_rd_data = r_w[AW'(cfg_addr)];
`ifdef TM_LIF_SPIKE_COUNT_EN
        else if (cfg_addr >= CNT_BASE_ADDR && (cfg_addr - CNT_BASE_ADDR) < NOUT_A)
            w_rd_data = WIDTH'(r_cnt[J_W'(cfg_addr - CNT_BASE_ADDR)]);
`endif
    end

    assign in_ready    = (r_state == IDLE) && !rst;
    assign busy        = (r_state != IDLE);
    assign out_valid   = r_out_valid;
    assign out_spikes  = r_out_spikes;
    assign cfg_rd_data = r_rd_data;

endmodule

// File: tb/tb_tm_lif_layer.sv
// Scoreboard bench for tm_lif_layer: a plain-arithmetic LIF model predicts each timestep's spikes.
module tb_tm_lif_layer;
    localparam int W = 16, NI = 4, NO = 3, RW = 8;
    localparam int LAT = NO * (NI + 1) + 1;

    logic          clk = 1'b0, rst = 1'b1;
    logic          cfg_wr_en = 1'b0;
    logic [15:0]   cfg_addr = '0;
    logic [W-1:0]  cfg_wr_data = '0, cfg_rd_data;
    logic [W-1:0]  threshold = '0, leak = '0, reset_potential = '0, refractory_cycles = '0;
    logic          in_valid = 1'b0, in_ready, out_valid, busy;
    logic [NI-1:0] in_spikes = '0;
    logic [NO-1:0] out_spikes;

    always #5 clk = ~clk;

    tm_lif_layer #(.WIDTH(W), .NUM_IN(NI), .NUM_OUT(NO), .REF_W(RW)) dut (
        .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
        .cfg_wr_data(cfg_wr_data), .cfg_rd_data(cfg_rd_data), .threshold(threshold),
        .leak(leak), .reset_potential(reset_potential), .refractory_cycles(refractory_cycles),
        .in_valid(in_valid), .in_ready(in_ready), .in_spikes(in_spikes),
        .out_valid(out_valid), .out_spikes(out_spikes), .busy(busy)
    );

    typedef struct { logic [NO-1:0] spk; int acc_cyc; } exp_t;
    exp_t sbq[$];
    int n_vec = 0, n_err = 0, cyc = 0;
    int mw[NI][NO], mv[NO], mref[NO], mcnt[NO];
    int t_thr = 0, t_lk = 0, t_rp = 0, t_rc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: one whole timestep, neuron by neuron.
    function automatic logic [NO-1:0] model_step(logic [NI-1:0] s);
        logic [NO-1:0] r = '0;
        for (int j = 0; j < NO; j++) begin
            int acc = 0, vn;
            for (int i = 0; i < NI; i++) if (s[i]) acc += mw[i][j];
            if (mref[j] != 0) mref[j]--;
            else begin
                vn = mv[j] - t_lk + acc;
                if (vn > 32767) vn = 32767;
                if (vn < -32768) vn = -32768;
                if (vn >= t_thr) begin
                    r[j] = 1'b1;
                    mv[j] = t_rp;
                    mref[j] = (t_rc < 0) ? 0 : ((t_rc > 255) ? 255 : t_rc);
`ifdef TM_LIF_SPIKE_COUNT_EN
                    if (mcnt[j] < 65535) mcnt[j]++;
`endif
                end else mv[j] = vn;
            end
        end
        return r;
    endfunction

    function automatic int model_read(int addr);
        if (addr < NI * NO) return mw[addr / NO][addr % NO];
`ifdef TM_LIF_SPIKE_COUNT_EN
        if (addr >= 32'h8000 && addr < 32'h8000 + NO) return mcnt[addr - 32'h8000];
`endif
        return 0;
    endfunction

    function automatic void model_reset();
        for (int j = 0; j < NO; j++) begin
            mv[j] = 0; mref[j] = 0; mcnt[j] = 0;
            for (int i = 0; i < NI; i++) mw[i][j] = 0;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_out_valid: got out_spikes=%b, required no result", out_spikes);
            end else begin
                e = sbq.pop_front();
                check("out_spikes", int'(out_spikes), int'(e.spk));
                check("latency", cyc - e.acc_cyc, LAT);
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle: in_ready stayed 0, required 1");
        end
    endtask

    task automatic run_step(logic [NI-1:0] s, bit bump);
        exp_t e;
        wait_idle();
        in_spikes = s;
        in_valid  = 1'b1;
        e.spk     = model_step(s);
        e.acc_cyc = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        in_spikes = NI'($urandom);
        if (bump) begin
            repeat (3) @(negedge clk);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic set_cfg(int thr, int lk, int rp, int rc);
        wait_idle();
        t_thr = thr; t_lk = lk; t_rp = rp; t_rc = rc;
        threshold = W'(thr); leak = W'(lk); reset_potential = W'(rp); refractory_cycles = W'(rc);
    endtask

    task automatic wr(int addr, int data);
        logic signed [W-1:0] d16;
        wait_idle();
        d16 = W'(data);
        cfg_wr_en = 1'b1; cfg_addr = 16'(addr); cfg_wr_data = d16;
        @(negedge clk);
        cfg_wr_en = 1'b0;
        if (addr < NI * NO) mw[addr / NO][addr % NO] = int'(d16);
`ifdef TM_LIF_SPIKE_COUNT_EN
        if (addr >= 32'h8000 && addr < 32'h8000 + NO) mcnt[addr - 32'h8000] = 0;
`endif
    endtask

    task automatic rd(string name, int addr);
        int act;
        wait_idle();
        cfg_addr = 16'(addr);
        @(negedge clk);
        act = (addr < NI * NO) ? int'($signed(cfg_rd_data)) : int'(cfg_rd_data);
        check(name, act, model_read(addr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_spikes", int'(out_spikes), 0);
        check("rst_cfg_rd_data", int'(cfg_rd_data), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);

        set_cfg(1, 0, 0, 0);
        run_step(4'b0000, 1'b0);

        wr(1, 100);
        set_cfg(100, 0, 0, 0);
        run_step(4'b0001, 1'b0);
        rd("rd_w01", 1);
        wr(12, 555);
        rd("rd_oob12", 12);
        rd("rd_oob7fff", 16'h7fff);

        set_cfg(100, 0, 0, 2);
        for (int k = 0; k < 4; k++) run_step(4'b0001, k == 1);

        wr(0, 32767);
        set_cfg(32767, -100, 32000, 0);
        for (int k = 0; k < 3; k++) run_step(4'b0001, 1'b0);
        wr(4, -32768);
        set_cfg(-32768, 100, 0, 1);
        for (int k = 0; k < 3; k++) run_step(4'b0011, 1'b0);

        // Abort a timestep with reset part-way through accumulation.
        wait_idle();
        in_spikes = 4'b0001; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_out_spikes", int'(out_spikes), 0);
        check("midrst_cfg_rd_data", int'(cfg_rd_data), 0);
        rst = 1'b0;
        model_reset();
        repeat (25) @(negedge clk);
        check("postrst_in_ready", int'(in_ready), 1);
        rd("rd_w00_cleared", 0);

        wr(0, 100);
        set_cfg(100, 0, 0, 0);
        for (int k = 0; k < 3; k++) run_step(4'b0001, 1'b0);
        rd("rd_cnt0", 16'h8000);
        wr(16'h8000, 0);
        rd("rd_cnt0_cleared", 16'h8000);
        rd("rd_cnt1", 16'h8001);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) wr(int'($urandom_range(0, 13)), int'($urandom_range(0, 65535)));
            if ($urandom_range(0, 2) == 0)
                set_cfg(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 400)) - 200,
                        int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 300)) - 5);
            run_step(NI'($urandom), $urandom_range(0, 3) == 0);
        end
        rd("rd_cnt0_rand", 16'h8000);
        rd("rd_cnt2_rand", 16'h8002);
        rd("rd_w_rand", int'($urandom_range(0, 11)));

        for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tm_lif_layer.md
Name: tm_lif_layer

Overview:
- Time-multiplexed, fully connected layer of leaky integrate-and-fire (LIF) neurons, parametrised in input count, neuron count and width.
- Successor to the fixed two-layer network: one shared accumulate/update datapath serves NUM_OUT neurons sequentially.
- Adds a timestep handshake, per-neuron refractory counters and on-chip weight storage.
- Weights are written through the register-style config port driven by the SPI slave. Layers chain via in_*/out_* ports.

Parameters:
- WIDTH, 16, signed width of weights, potentials and config values
- NUM_IN, 4, presynaptic inputs (1..64)
- NUM_OUT, 3, neurons in layer (1..64)
- REF_W, 8, refractory counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_wr_en  in  1  weight write strobe
- cfg_addr  in  16  config address
- cfg_wr_data  in  WIDTH  signed write data
- cfg_rd_data  out  WIDTH  registered read data
- threshold  in  WIDTH  signed firing threshold
- leak  in  WIDTH  signed per-step leak
- reset_potential  in  WIDTH  signed post-spike potential
- refractory_cycles  in  WIDTH  signed refractory length, in timesteps
- in_valid  in  1  timestep spikes valid
- in_ready  out  1  layer idle, accepts timestep
- in_spikes  in  NUM_IN  input spike vector
- out_valid  out  1  one-cycle pulse, result valid
- out_spikes  out  NUM_OUT  output spike vector, held until next result
- busy  out  1  FSM not IDLE

Behaviour:
- Reset values:
  - all potentials 0, refractory counters 0, weights 0
  - out_valid 0, out_spikes 0, cfg_rd_data 0, busy 0
  - in_ready 0 while rst is high, 1 in first cycle after reset
- Weight map: weight[i][j] at address i*NUM_OUT+j.
  - Writes to addresses at or above NUM_IN*NUM_OUT are ignored.
  - cfg_rd_data returns mem[cfg_addr] one cycle after cfg_addr is presented; out-of-range reads return 0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, capture in_spikes, set i=0, j=0, go to ACCUM.
  - ACCUM: one input per cycle. acc += in_spikes[i] ? weight[i][j] : 0. acc width is WIDTH+$clog2(NUM_IN)+1 (no overflow possible). acc is cleared when entering neuron j. After i=NUM_IN-1, go to UPDATE.
  - UPDATE, single cycle for neuron j:
    - If ref[j]!=0: decrement ref[j], hold v[j], spike 0.
    - Else compute v_new = sat_WIDTH(v[j] - leak + acc), saturating to signed WIDTH limits.
    - If v_new >= threshold (signed compare): spike 1, v[j]=reset_potential, ref[j]=clamp(refractory_cycles, 0, 2^REF_W-1). Negative values give 0.
    - Otherwise v[j]=v_new, spike 0.
    - Then: if j<NUM_OUT-1, increment j, reset i to 0, go to ACCUM; else go to DONE.
  - DONE: out_valid=1 for one cycle, out_spikes updated in the same cycle, go to IDLE.
- Latency: accept edge to out_valid is exactly NUM_OUT*(NUM_IN+1)+1 cycles. in_ready is low throughout.
- in_valid asserted while not idle is ignored; no queueing.
- Config inputs are sampled in each neuron's UPDATE cycle.
- Weight write and datapath read of the same entry in the same cycle: the read returns the old value; the write lands.
- Reset mid-operation: abort, no out_valid, all state returns to reset values.

Optional Feature:
- Macro: TM_LIF_SPIKE_COUNT_EN.
- Defined:
  - Per-neuron 16-bit saturating spike counters, incremented on each spike.
  - Readable at cfg_addr 16'h8000+j.
  - Any cfg write to that address clears the counter. If that write coincides with a spike, the clear wins.
- Undefined: no counters; those addresses read 0 and writes are ignored.

Decomposition:
- Package snn_pkg:
  - state enum (IDLE, ACCUM, UPDATE, DONE)
  - signed saturation function sat_to_width
  - constant CNT_BASE_ADDR=16'h8000
- One sub-module: lif_update_unit. Combinational; inputs v, acc, leak, threshold, reset_potential, refractory_cycles, ref; outputs v_next, ref_next, spike.
- Top holds the FSM, weight memory and state arrays.

Test Plan:
- Reset then idle → in_ready=1, out_spikes=0, cfg_rd_data=0; timestep with all-zero spikes, threshold=1 → out_valid after 16 cycles (defaults), out_spikes=000.
- Write weight[0][1]=100, threshold=100, leak=0, in_spikes=0001 → out_spikes=010 after 16 cycles; v[1]=reset_potential=0.
- refractory_cycles=2, neuron fires at step 1 with the same stimulus → steps 2 and 3 output 0, step 4 fires again.
- v near +32767, weight 32767, leak=-100 → v saturates at 32767 with no wrap; threshold=-32768 then fires every non-refractory step.
- in_valid pulsed during busy, and rst asserted mid-ACCUM → the pulse is ignored; after reset no out_valid, all state zero, next timestep behaves as after power-up.
- With TM_LIF_SPIKE_COUNT_EN: 3 spikes on neuron 0, read 16'h8000 → 3; write 16'h8000 → subsequent read 0.
